// File: rtl/imem_loader_if.sv
// Load-side and instruction-memory-side signals of imem_loader.
//   slave  : the loader (consumes the byte stream, drives memory/core control)
//   master : the environment (boot source, memory, core)
// Signals: start/in_valid/in_data/in_ready form the byte stream handshake;
// imem_we/imem_addr/imem_wdata form the memory write port; core_rst, done,
// error and words_loaded report load status.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
               core_rst, done, error, words_loaded
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               core_rst, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts a byte stream: 16-bit word count N (MSB first), 4*N instruction
// bytes (big-endian words), one XOR checksum byte over all preceding bytes.
// Words are written to addresses 0..N-1; the core is held in reset until the
// image is fully loaded and the checksum matches.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   ld   - imem_loader_if.slave (stream in, memory write port, status out)
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave ld
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [23:0]       word_q, word_d;     // first three bytes of current word
    logic [1:0]        bcnt_q, bcnt_d;
    logic [15:0]       acc_q, acc_d;       // words accepted from the stream
    logic [15:0]       wl_q, wl_d;         // words actually written
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        in_ready;
    logic        take;
    logic [15:0] n_len;

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
    assign take     = ld.in_valid && in_ready;
    assign n_len    = {len_q[15:8], ld.in_data};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        chk_d   = chk_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        acc_d   = acc_q;
        wl_d    = we_q ? wl_q + 16'd1 : wl_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (ld.start) begin
                    state_d = S_LEN_HI;
                    chk_d   = '0;
                    wl_d    = '0;
                    acc_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_d[15:8] = ld.in_data;
                    chk_d       = chk_q ^ ld.in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_d = n_len;
                    chk_d = chk_q ^ ld.in_data;
                    if (32'(n_len) > DEPTH)  state_d = S_ERR;
                    else if (n_len == 16'd0) state_d = S_CHK;
                    else                     state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (take) begin
                    chk_d  = chk_q ^ ld.in_data;
                    word_d = {word_q[15:0], ld.in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Write issues next cycle; the accepted-word count
                        // equals words_loaded at that point.
                        we_d    = 1'b1;
                        addr_d  = acc_q[ADDR_W-1:0];
                        wdata_d = {word_q, ld.in_data};
                        acc_d   = acc_q + 16'd1;
                        if (acc_q + 16'd1 == len_q) state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (take) state_d = (ld.in_data == chk_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags follow the next state; core reset releases only once the
    // loader has already sat in DONE for a cycle and is not restarting.
    assign done_d     = (state_d == S_DONE);
    assign err_d      = (state_d == S_ERR);
    assign core_rst_d = !((state_q == S_DONE) && (state_d == S_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            chk_q      <= '0;
            word_q     <= '0;
            bcnt_q     <= '0;
            acc_q      <= '0;
            wl_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            acc_q      <= acc_d;
            wl_q       <= wl_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ld.in_ready     = in_ready;
    assign ld.imem_we      = we_q;
    assign ld.imem_addr    = addr_q;
    assign ld.imem_wdata   = wdata_q;
    assign ld.core_rst     = core_rst_q;
    assign ld.done         = done_q;
    assign ld.error        = err_q;
    assign ld.words_loaded = wl_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the pipelined core fetches from.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses starting at 0.
- Holds the core in reset until a complete image with a correct checksum has been loaded.
- Sits between the external load interface and the instruction ROM write port; drives the core's active-high rst.

Parameters:
ADDR_W, 8, width of the instruction memory word address; DEPTH = 2**ADDR_W words.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  one-cycle pulse; begins a load
in_valid  in  1  byte available on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction memory write enable, one cycle per word
imem_addr  out  ADDR_W  word address, PC units (PC+1 = next word)
imem_wdata  out  32  instruction word
core_rst  out  1  active-high reset to the core datapath
done  out  1  image loaded and verified
error  out  1  load failed (bad length or checksum)
words_loaded  out  16  count of words written in the current load

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; core_rst=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; error=0; words_loaded=0; byte counter, length register and checksum accumulator all 0.
- Byte transfer: a byte is accepted on a rising clk edge with in_valid=1 and in_ready=1.
- in_ready is a registered/state-decoded output: 1 in LEN_HI, LEN_LO, DATA and CHK; 0 in IDLE, DONE and ERR.
- Stream format: length N (16-bit, high byte first), then 4*N data bytes (each word MSB first), then one checksum byte. The checksum is the XOR of every preceding byte, including both length bytes.
- FSM:
  - IDLE: start=1 -> LEN_HI. Clear checksum, words_loaded and done/error; keep core_rst=1.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte, then:
    - N > DEPTH -> ERR; no memory write occurs.
    - N = 0 -> CHK.
    - otherwise -> DATA.
  - DATA: shift each accepted byte into a word register. After the 4th byte of a word, on the next cycle drive imem_we=1 for exactly one cycle with imem_addr = words_loaded[ADDR_W-1:0] and imem_wdata = the assembled word; words_loaded then increments.
    - Acceptance of the next word's bytes may overlap the write cycle.
    - After word N is accepted -> CHK; its write still issues in the following cycle.
  - CHK: accept byte. Equal to the running XOR -> DONE; otherwise -> ERR.
  - DONE: done=1; core_rst=0 from the cycle after entry.
  - ERR: error=1; core_rst stays 1. Words already written are not rolled back.
  - DONE/ERR + start=1 -> LEN_HI: core_rst=1 the next cycle; done and error cleared.
- start is ignored in LEN_HI, LEN_LO, DATA and CHK.
- in_valid with in_ready=0: the byte is not consumed. Idle gaps in in_valid stall the FSM with no state change.
- imem_we is never asserted outside the write cycle described above. imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-load: immediate abort to the reset values above. A pending write is dropped (imem_we goes 0 asynchronously).
- N = DEPTH is legal: the last write goes to address DEPTH-1 and the address does not wrap.

Test Plan:
1. Valid load: after reset release, start pulse; bytes 00 02 20 08 00 05 00 00 00 00 2F with in_valid held high -> two writes, (addr 0, 0x20080005) then (addr 1, 0x00000000). Then done=1, core_rst=0, words_loaded=2, error=0.
2. Bad checksum: same stream with final byte 00 -> both writes occur; error=1, done=0, core_rst stays 1.
3. Oversize length: ADDR_W=8, bytes 01 01 -> ERR after the second byte; imem_we never asserted; in_ready=0 afterwards.
4. Stalled source: stream of scenario 1 with 1-3 idle cycles between bytes -> same writes, same addresses and same final outputs as scenario 1; no extra imem_we pulses.
5. Reset mid-load: drive rst=0 after the 6th byte of scenario 1 -> all outputs take reset values in the same cycle, with no write of word 0. After rst=1, a start and a full scenario 1 stream succeed.
6. Zero length and reload: bytes 00 00 00 -> done=1 with no writes. A following start pulse sets core_rst=1 and done=0 on the next cycle, and a scenario 1 stream then completes normally.
